// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO32x8 buffer and the blocks around it.
package fifo_pkg;

  // Arbiter sequencing: waiting, serving one requester's burst, or pulsing the FIFO clear.
  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    CLEAR
  } arb_state_t;

  // Default FIFO geometry: depth and word width.
  localparam int FIFO_TAM  = 32;
  localparam int FIFO_SIZE = 8;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: finds the first set request strictly after last_idx,
// wrapping modulo N, so last_idx itself is considered last.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_idx,
  output logic                 valid,
  output logic [$clog2(N)-1:0] next_idx
);

  localparam int IW = $clog2(N);

  int unsigned   cand;
  logic [IW-1:0] cand_idx;

  // Scan from the farthest candidate back to the nearest so the nearest set bit wins.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    valid    = 1'b0;
    next_idx = last_idx;
    cand     = '0;
    cand_idx = '0;
    for (int k = N; k >= 1; k--) begin
      cand = 32'(last_idx) + 32'(k);
      if (cand >= 32'(N)) cand = cand - 32'(N);
      cand_idx = IW'(cand);
      if (req[cand_idx]) begin
        valid    = 1'b1;
        next_idx = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter for the shared FIFO write port, with a clear
// sequencer that issues a timed CLEAR_N pulse only between bursts.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int N          = 4,
  parameter int size       = FIFO_SIZE,
  parameter int MAX_BURST  = 4,
  parameter int CLR_CYCLES = 2
) (
  input  logic                 CLOCK,
  input  logic                 RESET_N,
  input  logic [N-1:0]         REQ,
  input  logic [N*size-1:0]    DIN,
  output logic [N-1:0]         ACK,
  output logic [$clog2(N)-1:0] GNT_ID,
  output logic                 BUSY,
  input  logic                 CLR_REQ,
  output logic                 CLR_DONE,
  input  logic                 F_FULL_N,
  output logic                 WRITE,
  output logic [size-1:0]      DATA_IN,
  output logic                 CLEAR_N
);

  localparam int            IW         = $clog2(N);
  localparam int            BW         = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [3:0]    CLR_LAST   = 4'(CLR_CYCLES - 1);
  localparam logic [IW-1:0] GNT_RESET  = IW'(N - 1);

  arb_state_t    state_q,   state_d;
  logic [IW-1:0] gnt_q,     gnt_d;
  logic [BW-1:0] burst_q,   burst_d;
  logic [3:0]    clr_cnt_q, clr_cnt_d;
  logic          pend_q,    pend_d;
  logic          clear_n_q, clear_n_d;
  logic          done_q,    done_d;

  logic          req_cur;
  logic          write;
  logic          burst_end;
  logic          pend_eff;
  logic          arb;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;

  rr_pick #(.N(N)) u_pick (
    .req      (REQ),
    .last_idx (gnt_q),
    .valid    (pick_valid),
    .next_idx (pick_idx)
  );

  // Datapath mux and handshake: only the granted requester can be acknowledged.
  always_comb begin
    req_cur = 1'b0;
    DATA_IN = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_q == IW'(i)) begin
        req_cur = REQ[i];
        DATA_IN = DIN[i*size +: size];
      end
    end
    write = (state_q == GRANT) && req_cur && F_FULL_N;
    ACK   = '0;
    for (int i = 0; i < N; i++) begin
      ACK[i] = write && (gnt_q == IW'(i));
    end
  end

  // A clear request seen this cycle counts immediately at an arbitration point.
  assign pend_eff  = pend_q || (CLR_REQ && (state_q != CLEAR));
  assign burst_end = !req_cur || (write && (burst_q == BURST_LAST));

  // Next-state logic: burst counting, clear timing and the arbitration decision.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    burst_d   = burst_q;
    clr_cnt_d = clr_cnt_q;
    pend_d    = pend_q;
    clear_n_d = clear_n_q;
    done_d    = 1'b0;
    arb       = 1'b0;

    if (CLR_REQ && (state_q != CLEAR)) pend_d = 1'b1;

    case (state_q)
      IDLE: arb = 1'b1;
      GRANT: begin
        if (burst_end)  arb     = 1'b1;
        else if (write) burst_d = burst_q + 1'b1;
      end
      CLEAR: begin
        if (clr_cnt_q == CLR_LAST) begin
          clear_n_d = 1'b1;
          done_d    = 1'b1;
          pend_d    = 1'b0;
          state_d   = IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (arb) begin
      if (pend_eff) begin
        state_d   = CLEAR;
        clear_n_d = 1'b0;
        clr_cnt_d = '0;
      end else if (pick_valid) begin
        state_d = GRANT;
        gnt_d   = pick_idx;
        burst_d = '0;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // State register; reset aborts any burst or clear and drops a pending clear.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      gnt_q     <= GNT_RESET;
      burst_q   <= '0;
      clr_cnt_q <= '0;
      pend_q    <= 1'b0;
      clear_n_q <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      burst_q   <= burst_d;
      clr_cnt_q <= clr_cnt_d;
      pend_q    <= pend_d;
      clear_n_q <= clear_n_d;
      done_q    <= done_d;
    end
  end

  assign GNT_ID   = gnt_q;
  assign BUSY     = (state_q != IDLE);
  assign CLR_DONE = done_q;
  assign CLEAR_N  = clear_n_q;
  assign WRITE    = write;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter with a small FIFO occupancy model.
module tb_fifo_wr_arbiter;
  import fifo_pkg::*;

  localparam int N  = 4;
  localparam int SZ = 8;

  logic            CLOCK = 1'b0;
  logic            RESET_N;
  logic [N-1:0]    REQ;
  logic [N*SZ-1:0] DIN;
  logic [N-1:0]    ACK;
  logic [1:0]      GNT_ID;
  logic            BUSY;
  logic            CLR_REQ;
  logic            CLR_DONE;
  logic            F_FULL_N;
  logic            WRITE;
  logic [SZ-1:0]   DATA_IN;
  logic            CLEAR_N;

  logic rd;
  int   fifo_cnt;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] stream [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

  fifo_wr_arbiter #(.N(N), .size(SZ), .MAX_BURST(4), .CLR_CYCLES(2)) dut (
    .CLOCK    (CLOCK),
    .RESET_N  (RESET_N),
    .REQ      (REQ),
    .DIN      (DIN),
    .ACK      (ACK),
    .GNT_ID   (GNT_ID),
    .BUSY     (BUSY),
    .CLR_REQ  (CLR_REQ),
    .CLR_DONE (CLR_DONE),
    .F_FULL_N (F_FULL_N),
    .WRITE    (WRITE),
    .DATA_IN  (DATA_IN),
    .CLEAR_N  (CLEAR_N)
  );

  always #5 CLOCK = ~CLOCK;

  // FIFO occupancy model: synchronous clear, write and read on the rising edge.
  assign F_FULL_N = (fifo_cnt != FIFO_TAM);
  always @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N)     fifo_cnt <= 0;
    else if (!CLEAR_N) fifo_cnt <= 0;
    else fifo_cnt <= fifo_cnt + ((WRITE && fifo_cnt < FIFO_TAM) ? 1 : 0)
                              - ((rd && fifo_cnt > 0) ? 1 : 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic set_din(input int i, input logic [7:0] v);
    DIN[i*SZ +: SZ] = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int g;
    RESET_N = 1'b0;
    REQ     = '0;
    DIN     = '0;
    CLR_REQ = 1'b0;
    rd      = 1'b0;

    // Reset values
    repeat (2) @(posedge CLOCK);
    #2;
    check("rst_gnt",     32'(GNT_ID),   32'd3);
    check("rst_busy",    32'(BUSY),     32'd0);
    check("rst_write",   32'(WRITE),    32'd0);
    check("rst_ack",     32'(ACK),      32'd0);
    check("rst_clear_n", 32'(CLEAR_N),  32'd1);
    check("rst_done",    32'(CLR_DONE), 32'd0);
    RESET_N = 1'b1;

    // Single requester 0, six-word stream: 4-word burst, re-grant, 2 more, no bubble
    tick();
    REQ = 4'b0001;
    set_din(0, stream[0]);
    #1;
    check("t1_idle_write", 32'(WRITE), 32'd0);
    for (int w = 0; w < 6; w++) begin
      tick();
      set_din(0, stream[w]);
      #1;
      check($sformatf("t1_write_%0d", w), 32'(WRITE),   32'd1);
      check($sformatf("t1_ack_%0d", w),   32'(ACK),     32'b0001);
      check($sformatf("t1_data_%0d", w),  32'(DATA_IN), 32'(stream[w]));
      check($sformatf("t1_gnt_%0d", w),   32'(GNT_ID),  32'd0);
    end
    tick();
    REQ = '0;
    #1;
    check("t1_tail_write", 32'(WRITE), 32'd0);
    check("t1_tail_busy",  32'(BUSY),  32'd1);
    tick();
    #1;
    check("t1_idle_busy", 32'(BUSY), 32'd0);

    // All four requesting: last grant was 0, so order is 1,2,3,0,1 with 4 words each
    REQ = 4'b1111;
    for (int i = 0; i < N; i++) set_din(i, 8'hB0 + 8'(i));
    tick();
    for (int j = 0; j < 20; j++) begin
      g = (1 + j / 4) % 4;
      #1;
      check($sformatf("t2_gnt_%0d", j),   32'(GNT_ID),  32'(g));
      check($sformatf("t2_write_%0d", j), 32'(WRITE),   32'd1);
      check($sformatf("t2_ack_%0d", j),   32'(ACK),     32'd1 << g);
      check($sformatf("t2_data_%0d", j),  32'(DATA_IN), 32'hB0 + 32'(g));
      tick();
    end
    REQ = '0;
    #1;
    check("t2_tail_write", 32'(WRITE), 32'd0);
    tick();
    #1;
    check("t2_idle_busy", 32'(BUSY), 32'd0);

    // Clear request on word 2 of requester 1's burst: burst completes, then clear
    REQ = 4'b0010;
    set_din(1, 8'hC0);
    tick();
    #1;
    check("t4_w0_ack",  32'(ACK),     32'b0010);
    check("t4_w0_data", 32'(DATA_IN), 32'hC0);
    tick();
    set_din(1, 8'hC1);
    CLR_REQ = 1'b1;
    #1;
    check("t4_w1_write", 32'(WRITE), 32'd1);
    tick();
    CLR_REQ = 1'b0;
    set_din(1, 8'hC2);
    #1;
    check("t4_w2_write",   32'(WRITE),   32'd1);
    check("t4_w2_clear_n", 32'(CLEAR_N), 32'd1);
    tick();
    set_din(1, 8'hC3);
    #1;
    check("t4_w3_write",   32'(WRITE),   32'd1);
    check("t4_w3_clear_n", 32'(CLEAR_N), 32'd1);
    tick();
    set_din(1, 8'hC4);
    #1;
    check("t4_c0_clear_n", 32'(CLEAR_N),  32'd0);
    check("t4_c0_ack",     32'(ACK),      32'd0);
    check("t4_c0_write",   32'(WRITE),    32'd0);
    check("t4_c0_busy",    32'(BUSY),     32'd1);
    check("t4_c0_done",    32'(CLR_DONE), 32'd0);
    tick();
    #1;
    check("t4_c1_clear_n", 32'(CLEAR_N), 32'd0);
    check("t4_c1_ack",     32'(ACK),     32'd0);
    tick();
    REQ = '0;
    #1;
    check("t4_done",      32'(CLR_DONE), 32'd1);
    check("t4_clear_n",   32'(CLEAR_N),  32'd1);
    check("t4_busy",      32'(BUSY),     32'd0);
    check("t4_fifo_used", 32'(fifo_cnt), 32'd0);
    tick();
    #1;
    check("t4_done_low", 32'(CLR_DONE), 32'd0);

    // Fill the FIFO from requester 2, then the grant holds while full
    REQ = 4'b0100;
    set_din(2, 8'hD2);
    tick();
    for (int i = 0; i < FIFO_TAM; i++) begin
      #1;
      check($sformatf("t3_fill_write_%0d", i), 32'(WRITE), 32'd1);
      check($sformatf("t3_fill_ack_%0d", i),   32'(ACK),   32'b0100);
      tick();
    end
    #1;
    check("t3_full",       32'(F_FULL_N), 32'd0);
    check("t3_full_write", 32'(WRITE),    32'd0);
    check("t3_full_ack",   32'(ACK),      32'd0);
    check("t3_full_gnt",   32'(GNT_ID),   32'd2);
    check("t3_full_busy",  32'(BUSY),     32'd1);
    tick();
    #1;
    check("t3_hold_write", 32'(WRITE), 32'd0);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    #1;
    check("t3_one_write", 32'(WRITE), 32'd1);
    check("t3_one_ack",   32'(ACK),   32'b0100);
    tick();
    #1;
    check("t3_refull_write", 32'(WRITE), 32'd0);
    check("t3_refull_ack",   32'(ACK),   32'd0);
    REQ = '0;
    tick();

    // Clear and request arrive together in IDLE: clear first, grant after CLR_DONE
    REQ     = 4'b0100;
    CLR_REQ = 1'b1;
    set_din(2, 8'hE2);
    #1;
    check("t5_idle_write", 32'(WRITE), 32'd0);
    tick();
    CLR_REQ = 1'b0;
    #1;
    check("t5_c0_clear_n", 32'(CLEAR_N), 32'd0);
    check("t5_c0_ack",     32'(ACK),     32'd0);
    check("t5_c0_busy",    32'(BUSY),    32'd1);
    tick();
    #1;
    check("t5_c1_clear_n", 32'(CLEAR_N), 32'd0);
    check("t5_c1_ack",     32'(ACK),     32'd0);
    tick();
    #1;
    check("t5_done",      32'(CLR_DONE), 32'd1);
    check("t5_clear_n",   32'(CLEAR_N),  32'd1);
    check("t5_done_ack",  32'(ACK),      32'd0);
    check("t5_fifo_used", 32'(fifo_cnt), 32'd0);
    tick();
    #1;
    check("t5_gnt",       32'(GNT_ID),   32'd2);
    check("t5_ack",       32'(ACK),      32'b0100);
    check("t5_data",      32'(DATA_IN),  32'hE2);
    check("t5_done_low",  32'(CLR_DONE), 32'd0);
    tick();
    REQ = '0;
    #1;
    check("t5_tail_write", 32'(WRITE), 32'd0);
    tick();

    // Reset in the middle of CLEAR: CLEAR_N rises at once, no CLR_DONE, pending lost
    CLR_REQ = 1'b1;
    tick();
    CLR_REQ = 1'b0;
    #1;
    check("t6_clear_n_low", 32'(CLEAR_N), 32'd0);
    #2;
    RESET_N = 1'b0;
    #1;
    check("t6_async_clear_n", 32'(CLEAR_N),  32'd1);
    check("t6_async_busy",    32'(BUSY),     32'd0);
    check("t6_async_gnt",     32'(GNT_ID),   32'd3);
    check("t6_async_done",    32'(CLR_DONE), 32'd0);
    tick();
    #1;
    check("t6_rst_done", 32'(CLR_DONE), 32'd0);
    RESET_N = 1'b1;
    tick();
    REQ = 4'b1010;
    set_din(1, 8'hF1);
    set_din(3, 8'hF3);
    #1;
    check("t6_rel_done",    32'(CLR_DONE), 32'd0);
    check("t6_rel_clear_n", 32'(CLEAR_N),  32'd1);
    check("t6_rel_busy",    32'(BUSY),     32'd0);
    tick();
    #1;
    check("t6_gnt",     32'(GNT_ID),  32'd1);
    check("t6_ack",     32'(ACK),     32'b0010);
    check("t6_data",    32'(DATA_IN), 32'hF1);
    check("t6_clear_n", 32'(CLEAR_N), 32'd1);
    tick();
    REQ = '0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
